// File: rtl/reduce_ingress_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reduce_ingress_queue_pkg
// Brief    : Shared flit layout, reduction opcodes and the binomial-tree
//            children-count function used on both sides of the reduction unit.
// Revision : 1.0 - initial release
// ============================================================================
package reduce_ingress_queue_pkg;

  // Header field offsets measured from the top of the payload. A flit is
  // {valid, op, alg_type, tag, context_id, rank, src, dst, payload}, so the
  // absolute position of any field is PAYLOAD_WIDTH + its offset.
  localparam int c_DST_OFF      = 0;
  localparam int c_DST_WIDTH    = 9;
  localparam int c_SRC_OFF      = 9;
  localparam int c_SRC_WIDTH    = 9;
  localparam int c_RANK_OFF     = 18;
  localparam int c_RANK_WIDTH   = 9;
  localparam int c_CTX_OFF      = 27;
  localparam int c_CTX_WIDTH    = 8;
  localparam int c_TAG_OFF      = 35;
  localparam int c_TAG_WIDTH    = 8;
  localparam int c_ALG_OFF      = 43;
  localparam int c_ALG_WIDTH    = 2;
  localparam int c_OP_OFF       = 45;
  localparam int c_OP_WIDTH     = 4;
  localparam int c_VALID_OFF    = 49;
  localparam int c_HEADER_WIDTH = 50;

  // Absolute positions for the default 32-bit payload build.
  localparam int c_DEFAULT_PAYLOAD_WIDTH = 32;
  localparam int c_DST_POS      = c_DEFAULT_PAYLOAD_WIDTH + c_DST_OFF;
  localparam int c_SRC_POS      = c_DEFAULT_PAYLOAD_WIDTH + c_SRC_OFF;
  localparam int c_RANK_POS     = c_DEFAULT_PAYLOAD_WIDTH + c_RANK_OFF;
  localparam int c_CTX_POS      = c_DEFAULT_PAYLOAD_WIDTH + c_CTX_OFF;
  localparam int c_TAG_POS      = c_DEFAULT_PAYLOAD_WIDTH + c_TAG_OFF;
  localparam int c_ALG_POS      = c_DEFAULT_PAYLOAD_WIDTH + c_ALG_OFF;
  localparam int c_OP_POS       = c_DEFAULT_PAYLOAD_WIDTH + c_OP_OFF;
  localparam int c_VALID_POS    = c_DEFAULT_PAYLOAD_WIDTH + c_VALID_OFF;
  localparam int c_FLIT_WIDTH   = c_DEFAULT_PAYLOAD_WIDTH + c_HEADER_WIDTH;
  localparam int c_CHILDREN_POS = c_FLIT_WIDTH;

  // Opcodes. The reduction family is recognised by op[3:2] == 2'b11.
  typedef enum logic [3:0] {
    OP_SHORT_BCAST     = 4'b0111,
    OP_SHORT_REDUCE    = 4'b1100,
    OP_SHORT_ALLREDUCE = 4'b1101,
    OP_LARGE_REDUCE    = 4'b1110,
    OP_LARGE_ALLREDUCE = 4'b1111
  } op_e;

  localparam logic [1:0] c_REDUCE_FAMILY = 2'b11;

  // Number of children this node has in a binomial tree rooted at 'root'.
  // Relative rank r = (me - root) mod 2^lg_numprocs; the root owns
  // lg_numprocs children, any other node owns trailing_zeros(r) children.
  // Non-reduction opcodes never have children.
  function automatic logic [7:0] children_count(
    input logic [8:0] me,
    input logic [8:0] root,
    input logic [3:0] op,
    input int         lg_numprocs
  );
    logic [8:0] mask;
    logic [8:0] rel;
    logic [7:0] cnt;
    logic       found;
    mask  = '0;
    cnt   = '0;
    found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mask[i] = (i < lg_numprocs);
    end
    rel = (me - root) & mask;
    if (op[3:2] == c_REDUCE_FAMILY) begin
      if (rel == '0) begin
        cnt = 8'(lg_numprocs);
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (!found && rel[i]) begin
            cnt   = 8'(i);
            found = 1'b1;
          end
        end
      end
    end
    return cnt;
  endfunction

endpackage : reduce_ingress_queue_pkg
`default_nettype wire

// File: rtl/reduce_ingress_queue_sync_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fwft_fifo
// Brief    : Single-clock first-word-fall-through FIFO. The head entry is
//            always visible on rd_data_o; an empty FIFO presents all zeros.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fwft_fifo #(
  parameter int WIDTH    = 85,
  parameter int LG_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic                rd_en_i,
  output logic [WIDTH-1:0]    rd_data_o,
  output logic [LG_DEPTH:0]   count_o,
  output logic                empty_o,
  output logic                full_o
);

  localparam int c_DEPTH = 1 << LG_DEPTH;

  logic [WIDTH-1:0]    mem_q [c_DEPTH];
  logic [LG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LG_DEPTH:0]   count_q, count_d;
  logic                push;
  logic                pop;

  // Status is decoded from the occupancy counter alone, so it never depends
  // combinationally on this cycle's wr_en_i / rd_en_i.
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (LG_DEPTH+1)'(c_DEPTH));
  assign count_o = count_q;

  // A push into a full FIFO or a pop from an empty one is silently ignored.
  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  // Show-ahead head: zeros when empty so downstream sees an invalid flit.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at c_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset drops every queued entry at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule : sync_fwft_fifo
`default_nettype wire

// File: rtl/reduce_ingress_queue.sv
`default_nettype none
// ============================================================================
// Module   : reduce_ingress_queue
// Brief    : Ingress buffer in front of the reduction unit. Tags each valid
//            flit with its binomial-tree children count, queues it in a FWFT
//            FIFO and counts flits discarded for a cleared valid bit.
// Revision : 1.0 - initial release
// ============================================================================
module reduce_ingress_queue
  import reduce_ingress_queue_pkg::*;
#(
  parameter logic [2:0] RANK_Z        = 3'b0,
  parameter logic [2:0] RANK_Y        = 3'b0,
  parameter logic [2:0] RANK_X        = 3'b0,
  parameter int         LG_NUMPROCS   = 3,
  parameter int         PAYLOAD_WIDTH = 32,
  parameter int         LG_DEPTH      = 4
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic [PAYLOAD_WIDTH+c_HEADER_WIDTH-1:0]         in_flit_i,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  output logic [PAYLOAD_WIDTH+c_HEADER_WIDTH+LG_NUMPROCS-1:0] packet_out_o,
  input  logic                                            rd_en_i,
  output logic [12:0]                                     fifo_counter_o,
  output logic                                            buf_empty_o,
  output logic                                            buf_full_o,
  output logic [15:0]                                     drop_count_o
);

  localparam int c_FLIT_W   = PAYLOAD_WIDTH + c_HEADER_WIDTH;
  localparam int c_ENTRY_W  = c_FLIT_W + LG_NUMPROCS;
  localparam int c_VALID_P  = PAYLOAD_WIDTH + c_VALID_OFF;
  localparam int c_RANK_P   = PAYLOAD_WIDTH + c_RANK_OFF;
  localparam int c_OP_P     = PAYLOAD_WIDTH + c_OP_OFF;

  logic [8:0]             me;
  logic [8:0]             root;
  logic [3:0]             op;
  logic [LG_NUMPROCS-1:0] children;
  logic [c_ENTRY_W-1:0]   entry;
  logic                   handshake;
  logic                   accept;
  logic                   drop;
  logic [LG_DEPTH:0]      occupancy;
  logic                   empty;
  logic                   full;
  logic [15:0]            drop_count_q, drop_count_d;

  // Own linearised rank; the children function keeps only the low bits.
  assign me   = {RANK_Z, RANK_Y, RANK_X};
  assign root = in_flit_i[c_RANK_P +: c_RANK_WIDTH];
  assign op   = in_flit_i[c_OP_P +: c_OP_WIDTH];

  assign children = LG_NUMPROCS'(children_count(me, root, op, LG_NUMPROCS));
  assign entry    = {children, in_flit_i};

  // in_ready comes only from registered occupancy, never from in_valid/rd_en.
  assign in_ready_o = !full;
  assign handshake  = in_valid_i && !full;
  assign accept     = handshake && in_flit_i[c_VALID_P];
  assign drop       = handshake && !in_flit_i[c_VALID_P];

  sync_fwft_fifo #(
    .WIDTH    (c_ENTRY_W),
    .LG_DEPTH (LG_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (accept),
    .wr_data_i (entry),
    .rd_en_i   (rd_en_i),
    .rd_data_o (packet_out_o),
    .count_o   (occupancy),
    .empty_o   (empty),
    .full_o    (full)
  );

  assign buf_empty_o    = empty;
  assign buf_full_o     = full;
  assign fifo_counter_o = 13'(occupancy);
  assign drop_count_o   = drop_count_q;

  // Saturating count of handshaked flits whose valid bit was clear.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Drop counter register, cleared with the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

endmodule : reduce_ingress_queue
`default_nettype wire

// File: tb/tb_reduce_ingress_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_reduce_ingress_queue
// Brief    : Scoreboard bench for reduce_ingress_queue (node x=2, 8 ranks,
//            depth 16) with directed cases and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reduce_ingress_queue;

  localparam int FW = 82;
  localparam int EW = 85;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] packet_out;
  logic          rd_en;
  logic [12:0]   fifo_counter;
  logic          buf_empty;
  logic          buf_full;
  logic [15:0]   drop_count;

  reduce_ingress_queue #(
    .RANK_Z        (3'd0),
    .RANK_Y        (3'd0),
    .RANK_X        (3'd2),
    .LG_NUMPROCS   (3),
    .PAYLOAD_WIDTH (32),
    .LG_DEPTH      (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_flit_i      (in_flit),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .packet_out_o   (packet_out),
    .rd_en_i        (rd_en),
    .fifo_counter_o (fifo_counter),
    .buf_empty_o    (buf_empty),
    .buf_full_o     (buf_full),
    .drop_count_o   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [EW-1:0] exp_q [$];
  int            drop_model;
  int            n_checks;
  int            n_errors;
  bit            mon_en;

  function automatic void chk(input string name, input logic [EW-1:0] act,
                              input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endfunction

  // Reference children count from the tree definition: this node is rank 2
  // of 8; the root has 3 children, others have trailing_zeros(relative rank).
  function automatic logic [2:0] model_children(input logic [FW-1:0] f);
    int root, r, n;
    int opv;
    root = int'(f[52:50]);
    opv  = int'(f[80:77]);
    if (opv < 12) return 3'd0;
    r = (2 - root + 8) % 8;
    if (r == 0) return 3'd3;
    n = 0;
    while (r % 2 == 0) begin
      r = r / 2;
      n++;
    end
    return 3'(n);
  endfunction

  function automatic logic [FW-1:0] mk_flit(input logic vbit, input logic [3:0] op,
                                            input logic [8:0] rank,
                                            input logic [31:0] payload);
    logic [FW-1:0] f;
    f = {$urandom, $urandom, $urandom};
    f[81]    = vbit;
    f[80:77] = op;
    f[58:50] = rank;
    f[31:0]  = payload;
    return f;
  endfunction

  // One clock of stimulus; the model decides acceptance from the occupancy
  // it tracks and records the expected entry once the edge has passed.
  task automatic cycle(input logic v, input logic [FW-1:0] f, input logic rd);
    bit acc, drp;
    in_valid = v;
    in_flit  = f;
    rd_en    = rd;
    acc = v && (exp_q.size() < 16) && f[81];
    drp = v && (exp_q.size() < 16) && !f[81];
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back({model_children(f), f});
    if (drp && drop_model != 16'hFFFF) drop_model++;
  endtask

  // Monitor: on every falling edge compare status and the show-ahead head
  // against the model, and retire the head when a pop is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      sz = exp_q.size();
      chk("fifo_counter", EW'(fifo_counter), EW'(sz));
      chk("buf_empty", EW'(buf_empty), EW'(sz == 0));
      chk("buf_full", EW'(buf_full), EW'(sz == 16));
      chk("in_ready", EW'(in_ready), EW'(sz < 16));
      chk("drop_count", EW'(drop_count), EW'(drop_model));
      if (sz > 0) chk("packet_out_head", packet_out, exp_q[0]);
      else        chk("packet_out_empty", packet_out, '0);
      if (rd_en && sz > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    logic [3:0]    op;
    n_checks   = 0;
    n_errors   = 0;
    drop_model = 0;
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_flit    = '0;
    rd_en      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    // Reset then idle.
    chk("rst_empty", EW'(buf_empty), EW'(1));
    chk("rst_count", EW'(fifo_counter), '0);
    chk("rst_packet", packet_out, '0);
    chk("rst_ready", EW'(in_ready), EW'(1));
    mon_en = 1'b1;
    cycle(1'b0, '0, 1'b0);

    // Directed children cases for node rank 2.
    f = mk_flit(1'b1, 4'b1100, 9'd0, 32'h11);
    cycle(1'b1, f, 1'b0);
    chk("short_reduce_root0", packet_out, {3'd1, f});
    chk("short_reduce_count", EW'(fifo_counter), EW'(1));
    cycle(1'b0, '0, 1'b1);
    f = mk_flit(1'b1, 4'b1100, 9'd2, 32'h22);
    cycle(1'b1, f, 1'b0);
    chk("children_root_self", EW'(packet_out[84:82]), EW'(3'd3));
    cycle(1'b0, '0, 1'b1);
    f = mk_flit(1'b1, 4'b1100, 9'd7, 32'h33);
    cycle(1'b1, f, 1'b0);
    chk("children_r3", EW'(packet_out[84:82]), EW'(3'd0));
    cycle(1'b0, '0, 1'b1);
    f = mk_flit(1'b1, 4'b0111, 9'd0, 32'h44);
    cycle(1'b1, f, 1'b0);
    chk("children_bcast", EW'(packet_out[84:82]), EW'(3'd0));
    cycle(1'b0, '0, 1'b1);

    // Fill to full, attempt one more, then drain in order.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, mk_flit(1'b1, 4'b1101, 9'($urandom_range(0, 7)), 32'(i)), 1'b0);
      if (i == 15) begin
        chk("full_flag", EW'(buf_full), EW'(1));
        chk("full_ready", EW'(in_ready), EW'(0));
      end
    end
    chk("full_after_17", EW'(fifo_counter), EW'(16));
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    chk("drained_empty", EW'(buf_empty), EW'(1));

    // Occupancy 5 with simultaneous push and pop across the pointer wrap.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, mk_flit(1'b1, 4'b1110, 9'($urandom_range(0, 7)), 32'(100 + i)), 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, mk_flit(1'b1, 4'b1111, 9'($urandom_range(0, 7)), 32'(200 + i)), 1'b1);
    chk("steady_count5", EW'(fifo_counter), EW'(5));
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

    // Invalid flit is dropped, not queued.
    cycle(1'b1, mk_flit(1'b0, 4'b1100, 9'd0, 32'h55), 1'b0);
    chk("drop_count_one", EW'(drop_count), EW'(1));
    chk("drop_not_queued", EW'(fifo_counter), EW'(0));

    // Asynchronous reset pulse between clock edges with three entries queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, mk_flit(1'b1, 4'b1100, 9'd1, 32'(300 + i)), 1'b0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    drop_model = 0;
    #0.5;
    chk("async_rst_empty", EW'(buf_empty), EW'(1));
    chk("async_rst_packet", packet_out, '0);
    chk("async_rst_drop", EW'(drop_count), EW'(0));
    #0.5;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 1) == 1) op = 4'hC + 4'($urandom_range(0, 3));
      else                           op = 4'($urandom_range(0, 15));
      f = mk_flit($urandom_range(0, 9) != 0, op, 9'($urandom),
                  32'($urandom));
      cycle($urandom_range(0, 9) < 7, f, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
    chk("final_empty", EW'(buf_empty), EW'(1));

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reduce_ingress_queue
`default_nettype wire
